// File: rtl/l1_sdram_arbiter.sv
// l1_sdram_arbiter
//   Arbitrates the L1 instruction-cache port (i_*) and the L1 data-cache
//   port (d_*) onto a single SDRAM controller bus (sdc_*). One port is
//   granted at a time. The request is registered onto the controller bus.
//   The result and a one-cycle done pulse go back to the granted port.
//
// Parameters
//   ROUND_ROBIN  1: ties alternate between ports; 0: data port wins ties
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   i_addr/i_data/i_we/i_start      instruction port request (start is a level)
//   i_q/i_done                      instruction read data (held), done pulse
//   d_addr/d_data/d_we/d_start      data port request
//   d_q/d_done                      data read data (held), done pulse
//   sdc_addr/sdc_data/sdc_we        registered request to the SDRAM controller
//   sdc_start                       held high until sdc_done is sampled
//   sdc_q/sdc_done                  controller read data and completion pulse
//
// Every output comes straight from a register.
module l1_sdram_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        i_we,
    input  logic        i_start,
    output logic [31:0] i_q,
    output logic        i_done,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_data,
    input  logic        d_we,
    input  logic        d_start,
    output logic [31:0] d_q,
    output logic        d_done,
    output logic [31:0] sdc_addr,
    output logic [31:0] sdc_data,
    output logic        sdc_we,
    output logic        sdc_start,
    input  logic [31:0] sdc_q,
    input  logic        sdc_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVE,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        grant_q;      // 0 = instruction port, 1 = data port
    logic        last_q;       // port served by the most recent transaction
    logic        grant_d;
    logic [31:0] sdc_addr_q;
    logic [31:0] sdc_data_q;
    logic        sdc_we_q;
    logic        sdc_start_q;
    logic [31:0] i_q_q;
    logic [31:0] d_q_q;
    logic        i_done_q;
    logic        d_done_q;

    // Port selection. Only used in IDLE when at least one start is high.
    // On a tie, round-robin picks the port not served last. last resets to 0,
    // so the data port wins the first tie.
    always_comb begin
        grant_d = grant_q;
        if (i_start && !d_start) begin
            grant_d = 1'b0;
        end else if (d_start && !i_start) begin
            grant_d = 1'b1;
        end else if (i_start && d_start) begin
            grant_d = (ROUND_ROBIN != 0) ? ~last_q : 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b0;
            sdc_addr_q  <= '0;
            sdc_data_q  <= '0;
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b0;
            i_q_q       <= '0;
            d_q_q       <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            // Done pulses last exactly one cycle.
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start || d_start) begin
                        grant_q     <= grant_d;
                        sdc_addr_q  <= grant_d ? d_addr : i_addr;
                        sdc_data_q  <= grant_d ? d_data : i_data;
                        sdc_we_q    <= grant_d ? d_we   : i_we;
                        sdc_start_q <= 1'b1;
                        state_q     <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    // Port inputs are ignored here. The request on sdc_* is frozen.
                    if (sdc_done) begin
                        if (!sdc_we_q) begin
                            if (grant_q) begin
                                d_q_q <= sdc_q;
                            end else begin
                                i_q_q <= sdc_q;
                            end
                        end
                        sdc_start_q <= 1'b0;
                        i_done_q    <= ~grant_q;
                        d_done_q    <= grant_q;
                        last_q      <= grant_q;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i_q       = i_q_q;
    assign i_done    = i_done_q;
    assign d_q       = d_q_q;
    assign d_done    = d_done_q;
    assign sdc_addr  = sdc_addr_q;
    assign sdc_data  = sdc_data_q;
    assign sdc_we    = sdc_we_q;
    assign sdc_start = sdc_start_q;

endmodule

// File: tb/tb_l1_sdram_arbiter.sv
// Testbench for l1_sdram_arbiter. Two instances share every input.
// Instance 0 uses round-robin and instance 1 uses fixed data priority.
// Their state timing is identical, so one stimulus stream drives both.
// Each instance is checked against its own reference model.
module tb_l1_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr, i_data, d_addr, d_data, sdc_q;
    logic        i_we, i_start, d_we, d_start, sdc_done;

    logic [31:0] o_iq[2], o_dq[2], o_addr[2], o_data[2];
    logic        o_idone[2], o_ddone[2], o_we[2], o_start[2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: q_m[dut][port] (port 0 = I, 1 = D), last_m[dut]
    logic [31:0] q_m[2][2];
    bit          last_m[2];

    always #5 clk = ~clk;

    l1_sdram_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_data(i_data), .i_we(i_we), .i_start(i_start),
        .i_q(o_iq[0]), .i_done(o_idone[0]),
        .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_start(d_start),
        .d_q(o_dq[0]), .d_done(o_ddone[0]),
        .sdc_addr(o_addr[0]), .sdc_data(o_data[0]), .sdc_we(o_we[0]),
        .sdc_start(o_start[0]), .sdc_q(sdc_q), .sdc_done(sdc_done)
    );

    l1_sdram_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset(reset),
        .i_addr(i_addr), .i_data(i_data), .i_we(i_we), .i_start(i_start),
        .i_q(o_iq[1]), .i_done(o_idone[1]),
        .d_addr(d_addr), .d_data(d_data), .d_we(d_we), .d_start(d_start),
        .d_q(o_dq[1]), .d_done(o_ddone[1]),
        .sdc_addr(o_addr[1]), .sdc_data(o_data[1]), .sdc_we(o_we[1]),
        .sdc_start(o_start[1]), .sdc_q(sdc_q), .sdc_done(sdc_done)
    );

    // Arbitration rule: a lone requester wins. On a tie, round-robin
    // serves the port not served last; otherwise D wins.
    function automatic bit pick(bit ir, bit dr, bit rr, bit last);
        if (ir && !dr) return 1'b0;
        if (dr && !ir) return 1'b1;
        return rr ? !last : 1'b1;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            q_m[d][0] = '0;
            q_m[d][1] = '0;
            last_m[d] = 1'b0;
        end
    endtask

    task automatic chk_q(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_iq"}, d, o_iq[d], q_m[d][0]);
            chk({tag, "_dq"}, d, o_dq[d], q_m[d][1]);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_start"}, d, o_start[d], 1'b0);
            chk({tag, "_done"}, d, {o_idone[d], o_ddone[d]}, 2'b00);
            chk({tag, "_bus"}, d, o_addr[d] | o_data[d] | {31'd0, o_we[d]}, '0);
        end
        chk_q(tag);
    endtask

    // Port inputs the arbiter must ignore while a transaction is in flight.
    task automatic scramble();
        i_addr  = $urandom;
        i_data  = $urandom;
        i_we    = 1'($urandom_range(0, 1));
        i_start = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_data  = $urandom;
        d_we    = 1'($urandom_range(0, 1));
        d_start = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        i_start  = 1'b0;
        d_start  = 1'b0;
        sdc_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One transaction. The caller sets up the port inputs before the IDLE edge.
    // lat counts the cycles with sdc_start high, up to and including the
    // sdc_done cycle (>= 2).
    task automatic serve_one(input int unsigned lat, input logic [31:0] rdata);
        bit          g[2];
        logic [31:0] ea[2], ed[2];
        logic        ew[2];
        for (int d = 0; d < 2; d++) begin
            g[d]  = pick(i_start, d_start, d == 0, last_m[d]);
            ea[d] = g[d] ? d_addr : i_addr;
            ed[d] = g[d] ? d_data : i_data;
            ew[d] = g[d] ? d_we   : i_we;
        end
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("grant_start", d, o_start[d], 1'b1);
            chk("grant_addr", d, o_addr[d], ea[d]);
            chk("grant_data", d, o_data[d], ed[d]);
            chk("grant_we", d, o_we[d], ew[d]);
            chk("grant_nodone", d, {o_idone[d], o_ddone[d]}, 2'b00);
        end
        for (int unsigned c = 1; c < lat; c++) begin
            scramble();
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk("hold_start", d, o_start[d], 1'b1);
                chk("hold_addr", d, o_addr[d], ea[d]);
                chk("hold_data", d, o_data[d], ed[d]);
                chk("hold_nodone", d, {o_idone[d], o_ddone[d]}, 2'b00);
            end
        end
        sdc_done = 1'b1;
        sdc_q    = rdata;
        scramble();
        @(posedge clk); #1;
        sdc_done = 1'b0;
        sdc_q    = $urandom;
        for (int d = 0; d < 2; d++) begin
            if (!ew[d]) q_m[d][g[d]] = rdata;
            last_m[d] = g[d];
            chk("cmpl_start", d, o_start[d], 1'b0);
            chk("cmpl_idone", d, o_idone[d], !g[d]);
            chk("cmpl_ddone", d, o_ddone[d], g[d]);
        end
        chk_q("cmpl");
        // A stray sdc_done while in DONE must be ignored.
        sdc_done = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        sdc_done = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("post_done", d, {o_idone[d], o_ddone[d]}, 2'b00);
            chk("post_start", d, o_start[d], 1'b0);
        end
        chk_q("post");
    endtask

    // An IDLE cycle with no request, plus an optional stray sdc_done.
    task automatic idle_step();
        i_start  = 1'b0;
        d_start  = 1'b0;
        sdc_done = 1'($urandom_range(0, 1));
        sdc_q    = $urandom;
        @(posedge clk); #1;
        sdc_done = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("idle_start", d, o_start[d], 1'b0);
            chk("idle_done", d, {o_idone[d], o_ddone[d]}, 2'b00);
        end
        chk_q("idle");
    endtask

    initial begin
        reset = 1'b1;
        i_addr = '0; i_data = '0; i_we = 1'b0; i_start = 1'b0;
        d_addr = '0; d_data = '0; d_we = 1'b0; d_start = 1'b0;
        sdc_q = '0; sdc_done = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all_zero("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rst_rel");

        // Single read on I
        i_start = 1'b1; i_addr = 32'h100; i_we = 1'b0; i_data = 32'h0;
        serve_one(4, 32'hDEADBEEF);

        // Write on D: d_q stays unchanged
        i_start = 1'b0;
        d_start = 1'b1; d_addr = 32'h2000; d_data = 32'h12345678; d_we = 1'b1;
        serve_one(3, 32'hCAFEF00D);

        // I requests while D is served; I is granted 2 edges after sdc_done
        i_start = 1'b0;
        d_start = 1'b1; d_addr = 32'h3000; d_we = 1'b0;
        serve_one(5, 32'h0BADF00D);
        i_start = 1'b1; i_addr = 32'h4000; i_we = 1'b0;
        d_start = 1'b0;
        serve_one(2, 32'h55AA33CC);

        idle_step();

        // Ties from reset. Round-robin serves D,I,D,I; fixed priority serves D always.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            i_start = 1'b1; i_addr = 32'h1000 + n; i_data = $urandom; i_we = 1'b0;
            d_start = 1'b1; d_addr = 32'h8000 + n; d_data = $urandom; d_we = 1'b0;
            serve_one(3, $urandom);
        end
        // D drops; I is served by both instances
        i_start = 1'b1; i_addr = 32'h1100; i_we = 1'b0;
        d_start = 1'b0;
        serve_one(2, $urandom);

        // Reset mid-SERVE: sdc_start drops without a clock edge and no done is issued
        i_start = 1'b0;
        d_start = 1'b1; d_addr = 32'h5000; d_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("pre_rst_start", d, o_start[d], 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        chk_all_zero("async_rst");
        @(posedge clk); #1;
        chk_all_zero("async_rst_hold");
        d_start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        d_start = 1'b1; d_addr = 32'h6000; d_we = 1'b0;
        serve_one(3, 32'h600DCAFE);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int unsigned r;
            r = $urandom_range(0, 7);
            if (r == 0) begin
                idle_step();
            end else begin
                i_addr = $urandom; i_data = $urandom; i_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_data = $urandom; d_we = 1'($urandom_range(0, 1));
                i_start = (r == 1 || r >= 3);
                d_start = (r >= 2);
                serve_one($urandom_range(2, 6), $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
